// File: rtl/mem_pkg.sv
// Shared encodings for the SRAM controller: memory request types,
// FSM states and port identifiers.
package mem_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2,
    WR3
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sram_controller.sv
// Arbitrates the CPU data port (A) and fetch port (B) onto one
// asynchronous 16-bit SRAM with registered, glitch-free strobes.
module sram_controller
  import mem_pkg::*;
#(
  parameter logic [1:0] ADDR_HIGH = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aAddr,
  input  logic [15:0] aWriteData,
  input  logic [1:0]  aMemControl,
  output logic [15:0] aReadData,
  output logic        aDone,
  input  logic        bReq,
  input  logic [15:0] bAddr,
  output logic [15:0] bReadData,
  output logic        bDone,
  output logic        stall,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_data_out,
  output logic        ram_data_oe,
  input  logic [15:0] ram_data_in,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        port_q, port_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] ardata_q, ardata_d;
  logic [15:0] brdata_q, brdata_d;
  logic        adone_q, adone_d;
  logic        bdone_q, bdone_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        doe_q, doe_d;
  logic        a_req;
  logic        fin;

  assign a_req = (aMemControl == MEM_READ) ||
                 (aMemControl == MEM_WRITE);

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (!done_q) begin
          if (aMemControl == MEM_READ) begin
            state_d = RD1;
            port_d  = PORT_A;
            addr_d  = {ADDR_HIGH, aAddr};
            wdata_d = aWriteData;
          end else if (aMemControl == MEM_WRITE) begin
            state_d = WR1;
            port_d  = PORT_A;
            addr_d  = {ADDR_HIGH, aAddr};
            wdata_d = aWriteData;
          end else if (bReq) begin
            state_d = RD1;
            port_d  = PORT_B;
            addr_d  = {ADDR_HIGH, bAddr};
            wdata_d = aWriteData;
          end
        end
      end
      RD1:     state_d = RD2;
      RD2:     state_d = IDLE;
      WR1:     state_d = WR2;
      WR2:     state_d = WR3;
      WR3:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are a function of the next state so they register cleanly.
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    doe_d  = 1'b0;
    unique case (state_d)
      RD1, RD2: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      WR1, WR3: begin
        ce_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      WR2: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    fin      = (state_q != IDLE) && (state_d == IDLE);
    done_d   = fin;
    adone_d  = fin && (port_q == PORT_A);
    bdone_d  = fin && (port_q == PORT_B);
    ardata_d = ardata_q;
    brdata_d = brdata_q;
    if (state_q == RD2) begin
      if (port_q == PORT_A) ardata_d = ram_data_in;
      else                  brdata_d = ram_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      port_q   <= PORT_A;
      addr_q   <= '0;
      wdata_q  <= '0;
      ardata_q <= '0;
      brdata_q <= '0;
      adone_q  <= 1'b0;
      bdone_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      doe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ardata_q <= ardata_d;
      brdata_q <= brdata_d;
      adone_q  <= adone_d;
      bdone_q  <= bdone_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      doe_q    <= doe_d;
    end
  end

  assign stall = !rst &&
                 ((state_q != IDLE) || (!done_q && (a_req || bReq)));

  assign aReadData    = ardata_q;
  assign bReadData    = brdata_q;
  assign aDone        = adone_q;
  assign bDone        = bdone_q;
  assign ram_addr     = addr_q;
  assign ram_data_out = wdata_q;
  assign ram_data_oe  = doe_q;
  assign ram_ce_n     = ce_n_q;
  assign ram_oe_n     = oe_n_q;
  assign ram_we_n     = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural async SRAM
// that commits a write on the cycle after the we_n low pulse.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aAddr, aWriteData;
  logic [1:0]  aMemControl;
  logic [15:0] aReadData;
  logic        aDone;
  logic        bReq;
  logic [15:0] bAddr;
  logic [15:0] bReadData;
  logic        bDone;
  logic        stall;
  logic [17:0] ram_addr;
  logic [15:0] ram_data_out;
  logic        ram_data_oe;
  logic [15:0] ram_data_in;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  logic [15:0] mem [0:1023];
  logic        we_low_prev = 1'b0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst),
    .aAddr(aAddr), .aWriteData(aWriteData),
    .aMemControl(aMemControl),
    .aReadData(aReadData), .aDone(aDone),
    .bReq(bReq), .bAddr(bAddr),
    .bReadData(bReadData), .bDone(bDone),
    .stall(stall),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out),
    .ram_data_oe(ram_data_oe), .ram_data_in(ram_data_in),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  assign ram_data_in = (!ram_ce_n && !ram_oe_n) ?
                       mem[ram_addr[9:0]] : 16'h0000;

  // Write lands in the hold cycle, once we_n has risen with data driven.
  always @(negedge clk) begin
    if (!ram_ce_n && ram_data_oe && ram_we_n && we_low_prev)
      mem[ram_addr[9:0]] <= ram_data_out;
    we_low_prev <= !ram_we_n && !ram_ce_n;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (aDone || bDone)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_port", {31'd0, bDone}, {31'd0, mon_e.port});
        check("sb_both_done", {31'd0, aDone && bDone}, 32'd0);
        if (mon_e.wr)
          check("sb_wmem", {16'd0, mem[mon_e.addr[9:0]]},
                {16'd0, mon_e.data});
        else if (mon_e.port)
          check("sb_brdata", {16'd0, bReadData}, {16'd0, mon_e.data});
        else
          check("sb_ardata", {16'd0, aReadData}, {16'd0, mon_e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic port, output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cyc++;
      if (port ? bDone : aDone) return;
    end
    check("done_timeout", 32'd0, 32'd1);
    cyc = -1;
  endtask

  task automatic strobes(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe},
          {28'd0, exp});
  endtask

  int c;
  int t[3];
  int nd;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 3);
    mem[10'h010] = 16'hBEEF;
    mem[10'h000] = 16'h0800;
    mem[10'h044] = 16'h5A5A;
    mem[10'h004] = 16'hCAFE;
    mem[10'h050] = 16'h1111;
    rst = 1'b1;
    aAddr = '0; aWriteData = '0; aMemControl = 2'b00;
    bReq = 1'b0; bAddr = '0;
    tick(); tick();
    strobes("rst_strobes", 4'b1110);
    check("rst_addr", {14'd0, ram_addr}, 32'd0);
    check("rst_wdata", {16'd0, ram_data_out}, 32'd0);
    check("rst_rdata", {aReadData, bReadData}, 32'd0);
    check("rst_done", {30'd0, aDone, bDone}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // A read
    aMemControl = 2'b01; aAddr = 16'h0010;
    sb_q.push_back('{1'b0, 1'b0, 16'h0010, 16'hBEEF});
    #1 check("rd_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    check("rd_addr", {14'd0, ram_addr}, 32'h00010);
    strobes("rd_strobe_c1", 4'b0010);
    check("rd_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    strobes("rd_strobe_c2", 4'b0010);
    check("rd_stall_c2", {31'd0, stall}, 32'd1);
    tick();
    check("rd_done_c3", {31'd0, aDone}, 32'd1);
    check("rd_data_c3", {16'd0, aReadData}, 32'h0000BEEF);
    check("rd_stall_c3", {31'd0, stall}, 32'd0);
    strobes("rd_strobe_c3", 4'b1110);
    aMemControl = 2'b00;
    tick();
    check("rd_idle_c4", {30'd0, aDone, stall}, 32'd0);

    // A write, address/data changed mid-access must be ignored
    aMemControl = 2'b10; aAddr = 16'h0020; aWriteData = 16'h1234;
    sb_q.push_back('{1'b0, 1'b1, 16'h0020, 16'h1234});
    tick();
    aAddr = 16'h0030; aWriteData = 16'hFFFF;
    strobes("wr_strobe_c1", 4'b0111);
    check("wr_addr_c1", {14'd0, ram_addr}, 32'h00020);
    check("wr_data_c1", {16'd0, ram_data_out}, 32'h1234);
    tick();
    strobes("wr_strobe_c2", 4'b0101);
    tick();
    strobes("wr_strobe_c3", 4'b0111);
    check("wr_addr_c3", {14'd0, ram_addr}, 32'h00020);
    check("wr_stall_c3", {31'd0, stall}, 32'd1);
    tick();
    check("wr_done_c4", {31'd0, aDone}, 32'd1);
    strobes("wr_strobe_c4", 4'b1110);
    check("wr_mem", {16'd0, mem[10'h020]}, 32'h1234);
    aMemControl = 2'b00;
    tick();

    // Simultaneous A read and B fetch
    aMemControl = 2'b01; aAddr = 16'h0044;
    bReq = 1'b1; bAddr = 16'h0000;
    sb_q.push_back('{1'b0, 1'b0, 16'h0044, 16'h5A5A});
    sb_q.push_back('{1'b1, 1'b0, 16'h0000, 16'h0800});
    wait_done(1'b0, c);
    check("ab_a_first_cyc", c, 32'd3);
    check("ab_done_stall", {30'd0, stall, bDone}, 32'd0);
    aMemControl = 2'b00;
    wait_done(1'b1, c);
    check("ab_b_cyc", c, 32'd4);
    check("ab_bdata", {16'd0, bReadData}, 32'h0800);
    bReq = 1'b0;
    tick();

    // Held fetch request repeats every 4 cycles
    bReq = 1'b1; bAddr = 16'h0004;
    for (int k = 0; k < 3; k++)
      sb_q.push_back('{1'b1, 1'b0, 16'h0004, 16'hCAFE});
    nd = 0; c = 0;
    for (int i = 0; i < 30 && nd < 3; i++) begin
      tick();
      c++;
      if (bDone) begin
        t[nd] = c;
        nd++;
        strobes("held_done_idle", 4'b1110);
        if (nd == 3) bReq = 1'b0;
      end
    end
    check("held_count", nd, 32'd3);
    check("held_first", t[0], 32'd3);
    check("held_gap1", t[1] - t[0], 32'd4);
    check("held_gap2", t[2] - t[1], 32'd4);
    tick();
    strobes("held_quiet", 4'b1110);

    // Reset in WR2 must abort without committing the write
    aMemControl = 2'b10; aAddr = 16'h0050; aWriteData = 16'h9999;
    tick(); tick();
    strobes("rw_in_wr2", 4'b0101);
    rst = 1'b1;
    tick();
    strobes("rw_strobes", 4'b1110);
    check("rw_nodone", {30'd0, aDone, bDone}, 32'd0);
    check("rw_rdata", {16'd0, aReadData}, 32'd0);
    check("rw_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0; aMemControl = 2'b00;
    tick();
    check("rw_mem", {16'd0, mem[10'h050]}, 32'h1111);
    check("rw_nodone2", {31'd0, aDone}, 32'd0);

    // Reserved control encoding
    aMemControl = 2'b11; bReq = 1'b0;
    #1 check("rsv_stall", {31'd0, stall}, 32'd0);
    tick(); tick();
    strobes("rsv_strobes", 4'b1110);
    check("rsv_nodone", {31'd0, aDone}, 32'd0);
    aMemControl = 2'b00;
    tick();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
